// File: rtl/ddr_frame_arbiter.sv
// rtl/ddr_frame_arbiter.sv - round-robin DDR burst scheduler with vsync-driven ping-pong frame banks
module ddr_frame_arbiter #(
    parameter int          ADDR_W        = 30,
    parameter int          CNT_W         = 10,
    parameter int          BURST_LEN     = 64,
    parameter int          FRAME_WORDS   = 76800,
    parameter logic [31:0] FRAME_STRIDE  = 32'h0020_0000,
    parameter int          RD_FIFO_DEPTH = 512
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vin_vs,
    input  logic              vout_vs,
    input  logic [CNT_W-1:0]  wr_fifo_cnt,
    input  logic [CNT_W-1:0]  rd_fifo_cnt,
    input  logic              cmd_rdy,
    input  logic              burst_done,
    output logic              cmd_en,
    output logic [2:0]        cmd_instr,
    output logic [5:0]        cmd_bl,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic              wr_bank,
    output logic              rd_bank,
    output logic              frame_write_done,
    output logic              frame_read_done
);
    localparam int                OFS_W      = $clog2(FRAME_WORDS + 1);
    localparam logic [OFS_W-1:0]  FRAME_END  = OFS_W'(FRAME_WORDS);
    localparam logic [OFS_W-1:0]  BURST_STEP = OFS_W'(BURST_LEN);
    localparam logic [CNT_W:0]    WR_THRESH  = (CNT_W + 1)'(BURST_LEN);
    localparam logic [CNT_W:0]    RD_THRESH  = (CNT_W + 1)'(RD_FIFO_DEPTH - BURST_LEN);

    typedef enum logic [2:0] {IDLE, ARB, WR_CMD, RD_CMD, WR_WAIT, RD_WAIT} state_t;

    state_t            state;
    logic [OFS_W-1:0]  wr_ofs;
    logic [OFS_W-1:0]  rd_ofs;
    logic [OFS_W-1:0]  wr_ofs_inc;
    logic [OFS_W-1:0]  rd_ofs_inc;
    logic              last_wr;
    logic              full_bank;
    logic              full_bank_nxt;
    logic [2:0]        vin_sync;
    logic [2:0]        vout_sync;
    logic              vin_rise;
    logic              vout_rise;
    logic              vin_pend;
    logic              vout_pend;
    logic              wr_req;
    logic              rd_req;

    assign cmd_bl     = 6'(BURST_LEN - 1);
    assign vin_rise   = vin_sync[1] & ~vin_sync[2];
    assign vout_rise  = vout_sync[1] & ~vout_sync[2];
    assign wr_req     = ({1'b0, wr_fifo_cnt} >= WR_THRESH) && (wr_ofs < FRAME_END);
    assign rd_req     = ({1'b0, rd_fifo_cnt} <= RD_THRESH) && (rd_ofs < FRAME_END);
    assign wr_ofs_inc = wr_ofs + BURST_STEP;
    assign rd_ofs_inc = rd_ofs + BURST_STEP;

    // A vout serviced in the same cycle as vin sees the bank that vin just completed.
    assign full_bank_nxt = (vin_pend && wr_ofs == FRAME_END) ? wr_bank : full_bank;

    function automatic logic [ADDR_W-1:0] burst_addr(input logic bank, input logic [OFS_W-1:0] ofs);
        logic [ADDR_W-1:0] base;
        base = bank ? ADDR_W'(FRAME_STRIDE) : '0;
        return base + (ADDR_W'(ofs) << 3);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            wr_ofs           <= '0;
            rd_ofs           <= '0;
            last_wr          <= 1'b0;
            full_bank        <= 1'b1;
            vin_sync         <= '0;
            vout_sync        <= '0;
            vin_pend         <= 1'b0;
            vout_pend        <= 1'b0;
            cmd_en           <= 1'b0;
            cmd_instr        <= 3'b000;
            cmd_addr         <= '0;
            wr_bank          <= 1'b0;
            rd_bank          <= 1'b1;
            frame_write_done <= 1'b0;
            frame_read_done  <= 1'b0;
        end else begin
            vin_sync         <= {vin_sync[1:0], vin_vs};
            vout_sync        <= {vout_sync[1:0], vout_vs};
            vin_pend         <= vin_pend | vin_rise;
            vout_pend        <= vout_pend | vout_rise;
            frame_write_done <= 1'b0;
            frame_read_done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (vin_pend || vout_pend) begin
                        // An edge landing in the service cycle itself stays pending.
                        if (vin_pend) begin
                            vin_pend  <= vin_rise;
                            wr_ofs    <= '0;
                            full_bank <= full_bank_nxt;
                            if (wr_ofs == FRAME_END) begin
                                wr_bank <= ~wr_bank;
                            end
                        end
                        if (vout_pend) begin
                            vout_pend <= vout_rise;
                            rd_ofs    <= '0;
                            rd_bank   <= full_bank_nxt;
                        end
                    end else if (wr_req || rd_req) begin
                        state <= ARB;
                    end
                end
                ARB: begin
                    if (wr_req && (!rd_req || !last_wr)) begin
                        state     <= WR_CMD;
                        last_wr   <= 1'b1;
                        cmd_en    <= 1'b1;
                        cmd_instr <= 3'b000;
                        cmd_addr  <= burst_addr(wr_bank, wr_ofs);
                    end else if (rd_req) begin
                        state     <= RD_CMD;
                        last_wr   <= 1'b0;
                        cmd_en    <= 1'b1;
                        cmd_instr <= 3'b001;
                        cmd_addr  <= burst_addr(rd_bank, rd_ofs);
                    end else begin
                        state <= IDLE;
                    end
                end
                WR_CMD: begin
                    if (cmd_rdy) begin
                        cmd_en <= 1'b0;
                        state  <= WR_WAIT;
                    end
                end
                RD_CMD: begin
                    if (cmd_rdy) begin
                        cmd_en <= 1'b0;
                        state  <= RD_WAIT;
                    end
                end
                WR_WAIT: begin
                    if (burst_done) begin
                        wr_ofs           <= wr_ofs_inc;
                        frame_write_done <= (wr_ofs_inc == FRAME_END);
                        state            <= IDLE;
                    end
                end
                RD_WAIT: begin
                    if (burst_done) begin
                        rd_ofs          <= rd_ofs_inc;
                        frame_read_done <= (rd_ofs_inc == FRAME_END);
                        state           <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ddr_frame_arbiter.sv
// tb/tb_ddr_frame_arbiter.sv - randomized self-checking bench for ddr_frame_arbiter
module tb_ddr_frame_arbiter;
    localparam int          ADDR_W        = 30;
    localparam int          CNT_W         = 10;
    localparam int          BURST_LEN     = 64;
    localparam int          FRAME_WORDS   = 76800;
    localparam logic [31:0] FRAME_STRIDE  = 32'h0020_0000;
    localparam int          RD_FIFO_DEPTH = 512;

    logic              clk = 1'b0;
    logic              rst;
    logic              vin_vs;
    logic              vout_vs;
    logic [CNT_W-1:0]  wr_fifo_cnt;
    logic [CNT_W-1:0]  rd_fifo_cnt;
    logic              cmd_rdy;
    logic              burst_done;
    logic              cmd_en;
    logic [2:0]        cmd_instr;
    logic [5:0]        cmd_bl;
    logic [ADDR_W-1:0] cmd_addr;
    logic              wr_bank;
    logic              rd_bank;
    logic              frame_write_done;
    logic              frame_read_done;

    int checks   = 0;
    int failures = 0;

    // Reference model: frame progress and bank bookkeeping only.
    int m_wr_ofs;
    int m_rd_ofs;
    bit m_wr_bank;
    bit m_rd_bank;
    bit m_full_bank;
    bit m_last_wr;

    logic [2:0]        got_instr;
    logic [ADDR_W-1:0] got_addr;
    int                got_lat;

    ddr_frame_arbiter #(
        .ADDR_W(ADDR_W), .CNT_W(CNT_W), .BURST_LEN(BURST_LEN), .FRAME_WORDS(FRAME_WORDS),
        .FRAME_STRIDE(FRAME_STRIDE), .RD_FIFO_DEPTH(RD_FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .vin_vs(vin_vs), .vout_vs(vout_vs),
        .wr_fifo_cnt(wr_fifo_cnt), .rd_fifo_cnt(rd_fifo_cnt),
        .cmd_rdy(cmd_rdy), .burst_done(burst_done),
        .cmd_en(cmd_en), .cmd_instr(cmd_instr), .cmd_bl(cmd_bl), .cmd_addr(cmd_addr),
        .wr_bank(wr_bank), .rd_bank(rd_bank),
        .frame_write_done(frame_write_done), .frame_read_done(frame_read_done)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [ADDR_W-1:0] exp_addr(input bit bank, input int ofs);
        longint a;
        a = (bank ? longint'(FRAME_STRIDE) : 64'd0) + longint'(ofs) * 8;
        return a[ADDR_W-1:0];
    endfunction

    task automatic model_reset();
        m_wr_ofs    = 0;
        m_rd_ofs    = 0;
        m_wr_bank   = 0;
        m_rd_bank   = 1;
        m_full_bank = 1;
        m_last_wr   = 0;
    endtask

    task automatic model_vin();
        if (m_wr_ofs == FRAME_WORDS) begin
            m_full_bank = m_wr_bank;
            m_wr_bank   = ~m_wr_bank;
        end
        m_wr_ofs = 0;
    endtask

    task automatic model_vout();
        m_rd_bank = m_full_bank;
        m_rd_ofs  = 0;
    endtask

    task automatic reset_dut();
        rst         = 1'b1;
        cmd_rdy     = 1'b0;
        burst_done  = 1'b0;
        vin_vs      = 1'b0;
        vout_vs     = 1'b0;
        wr_fifo_cnt = '0;
        rd_fifo_cnt = 10'd512;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // Called at a negedge with the DUT idle; ends at a negedge with the DUT idle again.
    task automatic do_burst(input int wc, input int rc, input int rdy_delay, input int wait_cycles, input bit vin_mid);
        bit                wr_req;
        bit                rd_req;
        bit                grant_wr;
        bit                seen;
        int                lat;
        logic [2:0]        ei;
        logic [ADDR_W-1:0] ea;
        wr_fifo_cnt = CNT_W'(wc);
        rd_fifo_cnt = CNT_W'(rc);
        cmd_rdy     = 1'b0;
        burst_done  = 1'b0;
        wr_req = (wc >= BURST_LEN) && (m_wr_ofs < FRAME_WORDS);
        rd_req = (rc <= RD_FIFO_DEPTH - BURST_LEN) && (m_rd_ofs < FRAME_WORDS);
        got_lat = 0;
        if (!wr_req && !rd_req) begin
            seen = 0;
            repeat (6) begin
                @(negedge clk);
                if (cmd_en !== 1'b0) seen = 1;
            end
            checks++;
            if (seen) begin
                failures++;
                $display("FAIL no_request_idle: cmd_en went high, required 0 (wc=%0d rc=%0d)", wc, rc);
            end
            return;
        end
        grant_wr  = (wr_req && rd_req) ? !m_last_wr : wr_req;
        m_last_wr = grant_wr;
        ei = grant_wr ? 3'b000 : 3'b001;
        ea = grant_wr ? exp_addr(m_wr_bank, m_wr_ofs) : exp_addr(m_rd_bank, m_rd_ofs);
        lat  = 0;
        seen = 0;
        while (!seen && lat < 20) begin
            @(negedge clk);
            lat++;
            seen = (cmd_en === 1'b1);
        end
        got_lat   = lat;
        got_instr = cmd_instr;
        got_addr  = cmd_addr;
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL cmd_timeout: cmd_en not seen in 20 cycles, required a command (wc=%0d rc=%0d)", wc, rc);
            return;
        end
        checks++;
        if (cmd_instr !== ei) begin
            failures++;
            $display("FAIL cmd_instr: got %b required %b", cmd_instr, ei);
        end
        checks++;
        if (cmd_addr !== ea) begin
            failures++;
            $display("FAIL cmd_addr: got 0x%08h required 0x%08h", cmd_addr, ea);
        end
        checks++;
        if (cmd_bl !== 6'd63) begin
            failures++;
            $display("FAIL cmd_bl: got %0d required 63", cmd_bl);
        end
        repeat (rdy_delay) begin
            @(negedge clk);
            checks++;
            if (cmd_en !== 1'b1 || cmd_instr !== ei || cmd_addr !== ea) begin
                failures++;
                $display("FAIL stall_hold: got en=%b instr=%b addr=0x%08h required en=1 instr=%b addr=0x%08h",
                         cmd_en, cmd_instr, cmd_addr, ei, ea);
            end
        end
        cmd_rdy = 1'b1;
        @(negedge clk);
        cmd_rdy = 1'b0;
        checks++;
        if (cmd_en !== 1'b0) begin
            failures++;
            $display("FAIL cmd_drop: cmd_en got %b required 0 after acceptance", cmd_en);
        end
        if (vin_mid) begin
            vin_vs = 1'b1;
            repeat (8) begin
                @(negedge clk);
                checks++;
                if (cmd_en !== 1'b0 || wr_bank !== m_wr_bank) begin
                    failures++;
                    $display("FAIL midburst_hold: got en=%b wr_bank=%b required en=0 wr_bank=%b", cmd_en, wr_bank, m_wr_bank);
                end
            end
            vin_vs = 1'b0;
        end else begin
            repeat (wait_cycles) begin
                @(negedge clk);
                checks++;
                if (cmd_en !== 1'b0) begin
                    failures++;
                    $display("FAIL wait_quiet: cmd_en got %b required 0 during burst", cmd_en);
                end
            end
        end
        burst_done = 1'b1;
        @(negedge clk);
        burst_done = 1'b0;
        if (grant_wr) m_wr_ofs += BURST_LEN;
        else          m_rd_ofs += BURST_LEN;
        checks++;
        if (frame_write_done !== (grant_wr && m_wr_ofs == FRAME_WORDS) ||
            frame_read_done  !== (!grant_wr && m_rd_ofs == FRAME_WORDS)) begin
            failures++;
            $display("FAIL frame_done: got wr=%b rd=%b required wr=%b rd=%b",
                     frame_write_done, frame_read_done,
                     grant_wr && m_wr_ofs == FRAME_WORDS, !grant_wr && m_rd_ofs == FRAME_WORDS);
        end
        if (vin_mid) model_vin();
    endtask

    task automatic pulse_vsync(input bit is_vin);
        wr_fifo_cnt = '0;
        rd_fifo_cnt = 10'd512;
        if (is_vin) vin_vs = 1'b1;
        else        vout_vs = 1'b1;
        repeat (3) @(negedge clk);
        vin_vs  = 1'b0;
        vout_vs = 1'b0;
        repeat (4) @(negedge clk);
        if (is_vin) model_vin();
        else        model_vout();
        checks++;
        if (wr_bank !== m_wr_bank || rd_bank !== m_rd_bank) begin
            failures++;
            $display("FAIL vsync_banks: got wr_bank=%b rd_bank=%b required wr_bank=%b rd_bank=%b",
                     wr_bank, rd_bank, m_wr_bank, m_rd_bank);
        end
    endtask

    task automatic test_reset();
        reset_dut();
        checks++;
        if (cmd_en !== 1'b0 || cmd_instr !== 3'b000 || cmd_addr !== '0) begin
            failures++;
            $display("FAIL reset_cmd: got en=%b instr=%b addr=0x%08h required 0/000/0", cmd_en, cmd_instr, cmd_addr);
        end
        checks++;
        if (cmd_bl !== 6'd63) begin
            failures++;
            $display("FAIL reset_bl: got %0d required 63", cmd_bl);
        end
        checks++;
        if (wr_bank !== 1'b0 || rd_bank !== 1'b1) begin
            failures++;
            $display("FAIL reset_banks: got wr=%b rd=%b required wr=0 rd=1", wr_bank, rd_bank);
        end
        checks++;
        if (frame_write_done !== 1'b0 || frame_read_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_done: got wr=%b rd=%b required 0 0", frame_write_done, frame_read_done);
        end
        do_burst(0, 512, 0, 0, 0);
    endtask

    task automatic test_single_write();
        do_burst(64, 512, 0, 1, 0);
        checks++;
        if (got_lat !== 2 || got_instr !== 3'b000 || got_addr !== 30'h0) begin
            failures++;
            $display("FAIL first_write: got lat=%0d instr=%b addr=0x%08h required lat=2 instr=000 addr=0", got_lat, got_instr, got_addr);
        end
        do_burst(64, 512, 0, 1, 0);
        checks++;
        if (got_addr !== 30'h200) begin
            failures++;
            $display("FAIL second_write: got addr=0x%08h required 0x200", got_addr);
        end
    endtask

    task automatic test_alternation();
        logic [2:0]        t_instr [4];
        logic [ADDR_W-1:0] t_addr  [4];
        t_instr = '{3'b000, 3'b001, 3'b000, 3'b001};
        t_addr  = '{30'h0, 30'h200000, 30'h200, 30'h200200};
        reset_dut();
        for (int i = 0; i < 4; i++) begin
            do_burst(100, 0, 0, 1, 0);
            checks++;
            if (got_instr !== t_instr[i] || got_addr !== t_addr[i]) begin
                failures++;
                $display("FAIL alternation[%0d]: got instr=%b addr=0x%08h required instr=%b addr=0x%08h",
                         i, got_instr, got_addr, t_instr[i], t_addr[i]);
            end
        end
    endtask

    task automatic test_cmd_stall();
        do_burst(100, 600, 5, 2, 0);
        checks++;
        if (got_instr !== 3'b000) begin
            failures++;
            $display("FAIL stall_instr: got %b required 000", got_instr);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            do_burst(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 0);
        end
    endtask

    task automatic test_full_frame();
        reset_dut();
        for (int i = 0; i < FRAME_WORDS / BURST_LEN; i++) begin
            do_burst(64, 512, 0, 0, 0);
        end
        do_burst(64, 512, 0, 0, 0);
        pulse_vsync(1'b1);
        checks++;
        if (wr_bank !== 1'b1) begin
            failures++;
            $display("FAIL full_frame_wr_bank: got %b required 1", wr_bank);
        end
        pulse_vsync(1'b0);
        checks++;
        if (rd_bank !== 1'b0) begin
            failures++;
            $display("FAIL full_frame_rd_bank: got %b required 0", rd_bank);
        end
        do_burst(0, 0, 0, 1, 0);
        checks++;
        if (got_instr !== 3'b001 || got_addr !== 30'h0) begin
            failures++;
            $display("FAIL full_frame_read: got instr=%b addr=0x%08h required 001/0", got_instr, got_addr);
        end
    endtask

    task automatic test_partial_frame();
        for (int i = 0; i < 100; i++) begin
            do_burst(64, 512, 0, 0, 0);
        end
        pulse_vsync(1'b1);
        checks++;
        if (wr_bank !== 1'b1) begin
            failures++;
            $display("FAIL partial_wr_bank: got %b required 1", wr_bank);
        end
        do_burst(64, 512, 0, 1, 0);
        checks++;
        if (got_addr !== 30'h200000) begin
            failures++;
            $display("FAIL partial_restart: got addr=0x%08h required 0x200000", got_addr);
        end
    endtask

    task automatic test_vsync_midburst();
        do_burst(64, 512, 0, 0, 1);
        do_burst(64, 512, 0, 1, 0);
        checks++;
        if (got_lat !== 3 || got_addr !== 30'h200000) begin
            failures++;
            $display("FAIL midburst_service: got lat=%0d addr=0x%08h required lat=3 addr=0x200000", got_lat, got_addr);
        end
    endtask

    task automatic test_reset_midcmd();
        int n;
        bit seen;
        wr_fifo_cnt = '0;
        rd_fifo_cnt = '0;
        n    = 0;
        seen = 0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            seen = (cmd_en === 1'b1);
        end
        checks++;
        if (!seen || cmd_instr !== 3'b001) begin
            failures++;
            $display("FAIL pre_reset_read: got seen=%0d instr=%b required 1/001", seen, cmd_instr);
        end
        rst         = 1'b1;
        rd_fifo_cnt = 10'd512;
        #1;
        checks++;
        if (cmd_en !== 1'b0 || wr_bank !== 1'b0 || rd_bank !== 1'b1) begin
            failures++;
            $display("FAIL async_reset: got en=%b wr_bank=%b rd_bank=%b required 0/0/1", cmd_en, wr_bank, rd_bank);
        end
        @(negedge clk);
        rst        = 1'b0;
        burst_done = 1'b1;
        model_reset();
        @(negedge clk);
        burst_done = 1'b0;
        do_burst(0, 0, 0, 1, 0);
        checks++;
        if (got_instr !== 3'b001 || got_addr !== 30'h200000) begin
            failures++;
            $display("FAIL post_reset_read: got instr=%b addr=0x%08h required 001/0x200000", got_instr, got_addr);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_alternation();
        test_cmd_stall();
        test_random();
        test_full_frame();
        test_partial_frame();
        test_vsync_midburst();
        test_reset_midcmd();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
